// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: requester-side and memory-side handshake signals.
// slave modport is the arbiter's view; master modport is the environment's view.
// Optional perf counter signals exist only when MEM_ARB_PERF_EN is defined.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128
);
  // Requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LINE_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [LINE_W-1:0]         rsp_rdata;
  // Memory side
  logic                      mem_valid;
  logic                      mem_rw;
  logic [ADDR_W-1:0]         mem_addr;
  logic [LINE_W-1:0]         mem_wdata;
  logic                      mem_ready;
  logic                      mem_rsp_valid;
  logic [LINE_W-1:0]         mem_rdata;
  // Status
  logic                      err_unexp_rsp;
`ifdef MEM_ARB_PERF_EN
  logic [NUM_REQ*16-1:0]     perf_grants;
  logic [31:0]               perf_wait_cycles;
`endif

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  mem_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_rw, mem_addr, mem_wdata,
    output err_unexp_rsp
`ifdef MEM_ARB_PERF_EN
    , output perf_grants, perf_wait_cycles
`endif
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    output mem_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_rw, mem_addr, mem_wdata,
    input  err_unexp_rsp
`ifdef MEM_ARB_PERF_EN
    , input perf_grants, perf_wait_cycles
`endif
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one cache-line memory port between
// NUM_REQ requesters, one transaction outstanding at a time.
// Optional feature macro: MEM_ARB_PERF_EN (adds saturating grant/stall counters).
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_gnt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_found;
  logic [IDX_W-1:0]    w_grant;
  logic [IDX_W:0]      w_idx;
  logic                w_accept;
  logic                w_capture;
  logic                w_unexp;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic [NUM_REQ-1:0]  w_rsp_valid;
  logic                w_mem_valid;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
      if (w_idx >= (IDX_W + 1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDX_W + 1)'(NUM_REQ);
      end
      if (!w_found && bus.req_valid[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[IDX_W-1:0];
      end
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_unexp     = 1'b0;
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_mem_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.mem_rsp_valid) w_unexp = 1'b1;
        if (w_found) begin
          w_req_ready[w_grant] = 1'b1;
          w_accept             = 1'b1;
          w_state_d            = StIssue;
        end
      end
      StIssue: begin
        w_mem_valid = 1'b1;
        if (bus.mem_ready) begin
          if (bus.mem_rsp_valid) begin
            w_capture = 1'b1;
            w_state_d = StResp;
          end else begin
            w_state_d = StWait;
          end
        end else if (bus.mem_rsp_valid) begin
          w_unexp = 1'b1;
        end
      end
      StWait: begin
        if (bus.mem_rsp_valid) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        w_rsp_valid[r_gnt] = 1'b1;
        if (bus.mem_rsp_valid) w_unexp = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register, grant pointer, latched request and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_gnt   <= w_grant;
        r_rw    <= bus.req_rw[w_grant];
        r_addr  <= bus.req_addr[w_grant*ADDR_W +: ADDR_W];
        r_wdata <= bus.req_wdata[w_grant*LINE_W +: LINE_W];
      end
      // Writes complete with an ack only; the last read line stays visible
      if (w_capture && !r_rw) r_rdata <= bus.mem_rdata;
      if (r_state == StResp) begin
        r_rr_ptr <= (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
      end
      if (w_unexp) r_err <= 1'b1;
    end
  end

  // Gate the combinational accept so nothing leaks out while reset is held
  assign bus.req_ready     = w_req_ready & {NUM_REQ{rst_n}};
  assign bus.rsp_valid     = w_rsp_valid;
  assign bus.rsp_rdata     = r_rdata;
  assign bus.mem_valid     = w_mem_valid;
  assign bus.mem_rw        = r_rw;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.err_unexp_rsp = r_err;

`ifdef MEM_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] r_perf_grants;
  logic [31:0]           r_perf_wait;

  // Saturating per-requester accept counters and ISSUE stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grants <= '0;
      r_perf_wait   <= '0;
    end else begin
      if (w_accept && (r_perf_grants[w_grant*16 +: 16] != 16'hFFFF)) begin
        r_perf_grants[w_grant*16 +: 16] <= r_perf_grants[w_grant*16 +: 16] + 16'd1;
      end
      if ((r_state == StIssue) && !bus.mem_ready && (r_perf_wait != 32'hFFFF_FFFF)) begin
        r_perf_wait <= r_perf_wait + 32'd1;
      end
    end
  end

  assign bus.perf_grants      = r_perf_grants;
  assign bus.perf_wait_cycles = r_perf_wait;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NUM_REQ=2, ADDR_W=32, LINE_W=128).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .LINE_W(128)) bus ();

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .LINE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full read transaction from an IDLE cycle whose inputs were just driven:
  // accept, ISSUE with mem_ready, WAIT with response, RESP; returns at the next IDLE cycle.
  task automatic run_txn(input string tag, input logic [1:0] exp_g,
                         input logic [31:0] exp_addr, input logic [127:0] rdata);
    #1 chk_r({tag, "_ready"}, bus.req_ready, exp_g);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1 chk_b({tag, "_mvalid"}, bus.mem_valid, 1'b1);
    chk_w({tag, "_maddr"}, 128'(bus.mem_addr), 128'(exp_addr));
    chk_b({tag, "_mrw"}, bus.mem_rw, 1'b0);
    @(negedge clk);
    bus.mem_ready     = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = rdata;
    #1 chk_b({tag, "_wait_mvalid"}, bus.mem_valid, 1'b0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1 chk_r({tag, "_rsp"}, bus.rsp_valid, exp_g);
    chk_w({tag, "_rdata"}, bus.rsp_rdata, rdata);
    @(negedge clk);
  endtask

  initial begin
    n_cmp             = 0;
    n_err             = 0;
    rst_n             = 1'b0;
    bus.req_valid     = 2'b01;
    bus.req_rw        = 2'b00;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;

    // Reset: every output low even with a request pending
    #3;
    chk_r("rst_ready", bus.req_ready, 2'b00);
    chk_r("rst_rsp", bus.rsp_valid, 2'b00);
    chk_b("rst_mvalid", bus.mem_valid, 1'b0);
    chk_w("rst_maddr", 128'(bus.mem_addr), 128'd0);
    chk_w("rst_rdata", bus.rsp_rdata, 128'd0);
    chk_b("rst_err", bus.err_unexp_rsp, 1'b0);

    // Single read from requester 0, response two cycles after mem_ready
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.req_addr = {32'h0, 32'h40};
    #1 chk_r("rd_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.mem_ready = 1'b1;
    #1 chk_b("rd_mvalid", bus.mem_valid, 1'b1);
    chk_w("rd_maddr", 128'(bus.mem_addr), 128'h40);
    chk_r("rd_ready_off", bus.req_ready, 2'b00);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk_b("rd_wait_mvalid", bus.mem_valid, 1'b0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = {16{8'hA5}};
    #1 chk_r("rd_no_early_rsp", bus.rsp_valid, 2'b00);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1 chk_r("rd_rsp", bus.rsp_valid, 2'b01);
    chk_w("rd_rdata", bus.rsp_rdata, {16{8'hA5}});
    @(negedge clk);
    #1 chk_r("rd_rsp_pulse", bus.rsp_valid, 2'b00);
    chk_b("rd_err", bus.err_unexp_rsp, 1'b0);

    // Contention: rr_ptr is 1 after the read, so grants go 1,0,1,0
    bus.req_valid = 2'b11;
    bus.req_addr  = {32'h200, 32'h100};
    run_txn("ct0", 2'b10, 32'h200, 128'h1111);
    run_txn("ct1", 2'b01, 32'h100, 128'h2222);
    run_txn("ct2", 2'b10, 32'h200, 128'h3333);
    run_txn("ct3", 2'b01, 32'h100, 128'h4444);

    // Write from requester 1 with 3 cycles of backpressure
    bus.req_valid = 2'b10;
    bus.req_rw    = 2'b10;
    bus.req_addr  = {32'h300, 32'h0};
    bus.req_wdata = {128'h1234, 128'h0};
    #1 chk_r("wr_ready", bus.req_ready, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid = 2'b00;
      bus.mem_ready = (i == 3);
      #1 chk_b("wr_mvalid", bus.mem_valid, 1'b1);
      chk_w("wr_wdata", bus.mem_wdata, 128'h1234);
      chk_b("wr_mrw", bus.mem_rw, 1'b1);
    end
    @(negedge clk);
    bus.mem_ready     = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = {16{8'hEE}};
    #1 chk_b("wr_wait_mvalid", bus.mem_valid, 1'b0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.req_rw        = 2'b00;
    #1 chk_r("wr_rsp", bus.rsp_valid, 2'b10);
    chk_w("wr_rdata_kept", bus.rsp_rdata, 128'h4444);
    @(negedge clk);

    // Coincident mem_ready and mem_rsp_valid: accept, ISSUE, RESP, then IDLE
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h0, 32'h80};
    #1 chk_r("co_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid     = 2'b00;
    bus.mem_ready     = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = {16{8'h5A}};
    #1 chk_b("co_mvalid", bus.mem_valid, 1'b1);
    @(negedge clk);
    bus.mem_ready     = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    #1 chk_r("co_rsp", bus.rsp_valid, 2'b01);
    chk_w("co_rdata", bus.rsp_rdata, {16{8'h5A}});
    chk_b("co_err", bus.err_unexp_rsp, 1'b0);
    @(negedge clk);
    #1 chk_r("co_idle_rsp", bus.rsp_valid, 2'b00);
    chk_b("co_idle_mvalid", bus.mem_valid, 1'b0);

    // Reset while waiting for the memory response
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h0, 32'h55};
    #1 chk_r("rw_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk_w("rw_maddr", 128'(bus.mem_addr), 128'h55);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    #1 chk_b("rw_mvalid", bus.mem_valid, 1'b0);
    chk_w("rw_maddr_clr", 128'(bus.mem_addr), 128'd0);
    chk_w("rw_rdata_clr", bus.rsp_rdata, 128'd0);
    chk_r("rw_rsp", bus.rsp_valid, 2'b00);
    chk_r("rw_ready_rst", bus.req_ready, 2'b00);
    @(negedge clk);
    chk_r("rw_rsp_hold", bus.rsp_valid, 2'b00);
    rst_n         = 1'b1;
    bus.req_valid = 2'b10;
    bus.req_addr  = {32'h66, 32'h0};
    run_txn("rw_new", 2'b10, 32'h66, 128'h6666);

    // Spurious response in IDLE sets the sticky error
    bus.req_valid     = 2'b00;
    bus.mem_rsp_valid = 1'b1;
    #1 chk_b("sp_err_pre", bus.err_unexp_rsp, 1'b0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1 chk_b("sp_err", bus.err_unexp_rsp, 1'b1);
    chk_r("sp_rsp", bus.rsp_valid, 2'b00);
    @(negedge clk);
    @(negedge clk);
    #1 chk_b("sp_err_sticky", bus.err_unexp_rsp, 1'b1);
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h0, 32'h77};
    run_txn("sp_txn", 2'b01, 32'h77, 128'h7777);
    bus.req_valid = 2'b00;
    #1 chk_b("sp_err_end", bus.err_unexp_rsp, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
